// File: rtl/polyphase_interp_fir.sv
`timescale 1ns/1ps
// Upsample-by-L polyphase FIR interpolator built around one time-shared signed MAC.
// Each accepted input sample produces L outputs (phase 0..L-1), each taking TAPS MAC cycles.
module polyphase_interp_fir #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 8,
  parameter int L      = 2,
  parameter int TAPS   = 4,
  parameter int ACC_W  = DATA_W + COEF_W + $clog2(TAPS),
  parameter int SHIFT  = 7
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst,
  input  logic                      coef_we,
  input  logic [$clog2(L*TAPS)-1:0] coef_addr,
  input  logic signed [COEF_W-1:0]  coef_din,
  input  logic signed [DATA_W-1:0]  s_data,
  input  logic                      s_valid,
  output logic                      s_ready,
  output logic signed [DATA_W-1:0]  m_data,
  output logic                      m_valid,
  input  logic                      m_ready
);

  // state | meaning
  // IDLE  | waiting for an input sample, s_ready high
  // MAC   | accumulating x[tap]*h[tap*L+phase], one tap per cycle
  // OUT   | presenting the rounded/saturated phase result until m_ready
  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  localparam int N      = L * TAPS;
  localparam int AW     = $clog2(N);
  localparam int TW     = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int PW     = $clog2(L);
  localparam int PROD_W = DATA_W + COEF_W;

  localparam logic signed [ACC_W:0] ROUND_K = (ACC_W+1)'(2**(SHIFT-1));
  localparam logic signed [ACC_W:0] SAT_HI  = {{(ACC_W+2-DATA_W){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_LO  = ~SAT_HI;

  state_t                   state;
  logic signed [DATA_W-1:0] x [TAPS];
  logic signed [COEF_W-1:0] h [N];
  logic signed [ACC_W-1:0]  acc;
  logic [PW-1:0]            phase;
  logic [TW-1:0]            tap;

  logic [AW-1:0]            h_idx;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W:0]    rounded;
  logic signed [ACC_W:0]    shifted;
  logic signed [DATA_W-1:0] sat_val;

  always_comb begin
    h_idx   = AW'(tap) * AW'(L) + AW'(phase);
    prod    = x[tap] * h[h_idx];
    // one guard bit so the rounding offset can never wrap the accumulator
    rounded = (ACC_W+1)'(acc) + ROUND_K;
    shifted = rounded >>> SHIFT;
    if (shifted > SAT_HI)
      sat_val = SAT_HI[DATA_W-1:0];
    else if (shifted < SAT_LO)
      sat_val = SAT_LO[DATA_W-1:0];
    else
      sat_val = shifted[DATA_W-1:0];
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state   <= IDLE;
      acc     <= '0;
      phase   <= '0;
      tap     <= '0;
      s_ready <= 1'b1;
      m_valid <= 1'b0;
      m_data  <= '0;
      for (int i = 0; i < TAPS; i++) x[i] <= '0;
      for (int k = 0; k < N; k++) h[k] <= '0;
    end else begin
      if (coef_we && (int'(coef_addr) < N))
        h[coef_addr] <= coef_din;

      case (state)
        IDLE: begin
          if (s_valid && s_ready) begin
            for (int i = TAPS-1; i > 0; i--) x[i] <= x[i-1];
            x[0]    <= s_data;
            phase   <= '0;
            tap     <= '0;
            acc     <= '0;
            s_ready <= 1'b0;
            state   <= MAC;
          end
        end
        MAC: begin
          acc <= acc + ACC_W'(prod);
          tap <= tap + 1'b1;
          if (tap == TW'(TAPS-1))
            state <= OUT;
        end
        OUT: begin
          // first OUT cycle latches the result; afterwards it is held until accepted
          if (!m_valid) begin
            m_valid <= 1'b1;
            m_data  <= sat_val;
          end else if (m_ready) begin
            m_valid <= 1'b0;
            if (phase == PW'(L-1)) begin
              s_ready <= 1'b1;
              state   <= IDLE;
            end else begin
              phase <= phase + 1'b1;
              tap   <= '0;
              acc   <= '0;
              state <= MAC;
            end
          end
        end
        default: begin
          s_ready <= 1'b1;
          m_valid <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_polyphase_interp_fir.sv
`timescale 1ns/1ps
// Self-checking bench for polyphase_interp_fir: fixed vector tables, hand-written corner
// sequences and randomized traffic against a plain-arithmetic convolution model.
module tb_polyphase_interp_fir;

  localparam int DATA_W = 16;
  localparam int COEF_W = 8;
  localparam int L      = 2;
  localparam int TAPS   = 4;
  localparam int N      = L * TAPS;
  localparam int SHIFT  = 7;

  logic                     ap_clk = 1'b0;
  logic                     ap_rst = 1'b1;
  logic                     coef_we = 1'b0;
  logic [$clog2(N)-1:0]     coef_addr = '0;
  logic signed [COEF_W-1:0] coef_din = '0;
  logic signed [DATA_W-1:0] s_data = '0;
  logic                     s_valid = 1'b0;
  logic                     s_ready;
  logic signed [DATA_W-1:0] m_data;
  logic                     m_valid;
  logic                     m_ready = 1'b1;

  always #5 ap_clk = ~ap_clk;

  polyphase_interp_fir #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .L(L), .TAPS(TAPS), .SHIFT(SHIFT)
  ) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_din(coef_din),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
  );

  typedef struct {
    int din;
    int exp0;
    int exp1;
  } vec_t;

  vec_t vecs [16];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   hist [TAPS];
  int   h_m  [N];
  int   got  [L];
  int   lat  [L];
  int   expv [L];
  int   bad;
  int   d;
  int   hold;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Direct convolution: output for phase p = sum_t x[n-t]*h[t*L+p], rounded then clamped.
  function automatic int model_out(input int p);
    longint acc;
    acc = 0;
    for (int t = 0; t < TAPS; t++)
      acc += longint'(hist[t]) * longint'(h_m[t*L+p]);
    acc = (acc + (longint'(1) << (SHIFT-1))) >>> SHIFT;
    if (acc > 32767) return 32767;
    if (acc < -32768) return -32768;
    return int'(acc);
  endfunction

  task automatic clear_model();
    for (int t = 0; t < TAPS; t++) hist[t] = 0;
    for (int k = 0; k < N; k++) h_m[k] = 0;
  endtask

  task automatic do_reset();
    ap_rst  = 1'b1;
    s_valid = 1'b0;
    coef_we = 1'b0;
    m_ready = 1'b1;
    repeat (2) @(negedge ap_clk);
    ap_rst = 1'b0;
    clear_model();
  endtask

  task automatic write_coef(input int k, input int v);
    coef_addr = ($clog2(N))'(k);
    coef_din  = COEF_W'(v);
    coef_we   = 1'b1;
    @(negedge ap_clk);
    coef_we   = 1'b0;
    h_m[k]    = v;
  endtask

  // Sends one sample and collects L outputs; phase 0 is held off for 'hold' cycles.
  task automatic send(input int din, input int hold_cycles);
    int cnt;
    int nbad;
    cnt = 0;
    while (!s_ready && cnt < 100) begin
      @(negedge ap_clk);
      cnt++;
    end
    check("s_ready_wait", int'(s_ready), 1);
    if (hold_cycles > 0) m_ready = 1'b0;
    s_data  = din[DATA_W-1:0];
    s_valid = 1'b1;
    @(negedge ap_clk);
    s_valid = 1'b0;
    for (int t = TAPS-1; t > 0; t--) hist[t] = hist[t-1];
    hist[0] = din;
    for (int p = 0; p < L; p++) begin
      expv[p] = model_out(p);
      cnt = 0;
      while (!m_valid && cnt < 50) begin
        @(negedge ap_clk);
        cnt++;
      end
      check("m_valid_wait", int'(m_valid), 1);
      got[p] = int'(m_data);
      lat[p] = cnt;
      if (hold_cycles > 0 && p == 0) begin
        nbad = 0;
        for (int c = 0; c < hold_cycles; c++) begin
          @(negedge ap_clk);
          if (!m_valid || int'(m_data) != got[p] || s_ready) nbad++;
        end
        check("backpressure_hold", nbad, 0);
        m_ready = 1'b1;
      end
      @(negedge ap_clk);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // impulse through h[k]=k+1, then saturation with all h=127
    vecs[0]  = '{din: 128,    exp0: 1,      exp1: 2};
    vecs[1]  = '{din: 0,      exp0: 3,      exp1: 4};
    vecs[2]  = '{din: 0,      exp0: 5,      exp1: 6};
    vecs[3]  = '{din: 0,      exp0: 7,      exp1: 8};
    vecs[4]  = '{din: 0,      exp0: 0,      exp1: 0};
    vecs[5]  = '{din: 0,      exp0: 0,      exp1: 0};
    vecs[6]  = '{din: 0,      exp0: 0,      exp1: 0};
    vecs[7]  = '{din: 0,      exp0: 0,      exp1: 0};
    vecs[8]  = '{din: 32767,  exp0: 32511,  exp1: 32511};
    vecs[9]  = '{din: 32767,  exp0: 32767,  exp1: 32767};
    vecs[10] = '{din: 32767,  exp0: 32767,  exp1: 32767};
    vecs[11] = '{din: 32767,  exp0: 32767,  exp1: 32767};
    vecs[12] = '{din: -32768, exp0: 32767,  exp1: 32767};
    vecs[13] = '{din: -32768, exp0: -2,     exp1: -2};
    vecs[14] = '{din: -32768, exp0: -32768, exp1: -32768};
    vecs[15] = '{din: -32768, exp0: -32768, exp1: -32768};

    do_reset();
    check("reset_m_valid", int'(m_valid), 0);
    check("reset_m_data", int'(m_data), 0);
    check("reset_s_ready", int'(s_ready), 1);

    for (int k = 0; k < N; k++) write_coef(k, k + 1);
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].din, 0);
      check($sformatf("impulse[%0d].p0", i), got[0], vecs[i].exp0);
      check($sformatf("impulse[%0d].p1", i), got[1], vecs[i].exp1);
      check("latency_first", lat[0], 5);
      check("latency_phase", lat[1], 5);
    end

    do_reset();
    for (int k = 0; k < N; k++) write_coef(k, 127);
    for (int i = 8; i < 16; i++) begin
      send(vecs[i].din, 0);
      check($sformatf("sat[%0d].p0", i), got[0], vecs[i].exp0);
      check($sformatf("sat[%0d].p1", i), got[1], vecs[i].exp1);
    end

    do_reset();
    write_coef(0, 64);
    send(1, 0);
    check("round_half_up", got[0], 1);
    check("round_zero_phase1", got[1], 0);
    do_reset();
    write_coef(0, 63);
    send(1, 0);
    check("round_below_half", got[0], 0);

    do_reset();
    for (int k = 0; k < N; k++) write_coef(k, 10 * k - 30);
    send(1000, 10);
    check("backpressure_p0", got[0], expv[0]);
    check("backpressure_p1", got[1], expv[1]);
    check("backpressure_latency", lat[1], 5);

    do_reset();
    for (int k = 0; k < N; k++) write_coef(k, k + 5);
    s_data  = 16'sd500;
    s_valid = 1'b1;
    @(negedge ap_clk);
    s_valid = 1'b0;
    repeat (2) @(negedge ap_clk);
    ap_rst = 1'b1;
    @(negedge ap_clk);
    check("midmac_reset_m_valid", int'(m_valid), 0);
    check("midmac_reset_s_ready", int'(s_ready), 1);
    ap_rst = 1'b0;
    clear_model();
    bad = 0;
    repeat (10) begin
      @(negedge ap_clk);
      if (m_valid) bad++;
    end
    check("midmac_no_partial_output", bad, 0);
    send(700, 0);
    check("midmac_coef_cleared_p0", got[0], 0);
    check("midmac_coef_cleared_p1", got[1], 0);

    do_reset();
    for (int k = 0; k < N; k++) write_coef(k, int'($urandom_range(0, 255)) - 128);
    for (int i = 0; i < 24; i++) begin
      if (i % 5 == 0)
        d = (i % 10 == 0) ? 32767 : -32768;
      else
        d = int'($urandom_range(0, 65535)) - 32768;
      hold = (i % 7 == 3) ? 3 : 0;
      send(d, hold);
      check($sformatf("rand[%0d].p0", i), got[0], expv[0]);
      check($sformatf("rand[%0d].p1", i), got[1], expv[1]);
      check($sformatf("rand[%0d].latency", i), lat[0], 5);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
